// File: rtl/spi_pkg.sv
// Purpose : shared SPI definitions (FSM states, default word width) used by
//           the master and by future slave revisions.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    TRAIL = 3'd4
  } spi_state_t;

  localparam int unsigned SPI_DATA_W = 4;

endpackage

// File: rtl/spi_tick_gen.sv
// Purpose : half-period counter; emits a one-cycle tick every CLK_DIV cycles.
// Latency : first tick CLK_DIV cycles after clear is sampled.
// Backpressure: none; free-running, restarted by clear.
// Ports   : clk, rst (async active-high), clear (restart count), tick (out).
module spi_tick_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Tick fires in the last cycle of each half-period; the count then wraps
  // to zero so it never runs past CLK_DIV-1.
  assign tick = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Purpose : SPI master (mode 0, active-high cs); serialises data_in MSB first
//           and captures miso into rx_data in the same transfer.
// Latency : busy/cs high for (2*DATA_W+1)*CLK_DIV cycles, done the cycle after.
// Backpressure: start is only accepted in IDLE; requests while busy are dropped.
// Ports   : clk, rst (async active-high), start, data_in, miso in;
//           sclk, cs, mosi, busy, done, rx_data out (all registered).
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W  = SPI_DATA_W,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              miso,
  output logic              sclk,
  output logic              cs,
  output logic              mosi,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  spi_state_t        state_q, state_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              sclk_q, sclk_d;
  logic              cs_q, cs_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;

  logic [DATA_W-1:0] tx_next;
  logic              tick;
  logic              clear;

  // Every state change restarts the half-period so each state lasts exactly
  // CLK_DIV cycles regardless of where the free-running count was in IDLE.
  assign clear = (state_d != state_q);

  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rx_data_d = rx_data_q;
    tx_next   = tx_sh_q << 1;

    case (state_q)
      IDLE: begin
        if (start) begin
          tx_sh_d   = data_in;
          bit_cnt_d = BW'(DATA_W - 1);
          cs_d      = 1'b1;
          busy_d    = 1'b1;
          mosi_d    = data_in[DATA_W-1];
          state_d   = LEAD;
        end
      end
      // LEAD and LOW both end with a rising sclk and a miso capture.
      LEAD, LOW: begin
        if (tick) begin
          sclk_d  = 1'b1;
          rx_sh_d = (rx_sh_q << 1) | DATA_W'(miso);
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (tick) begin
          sclk_d = 1'b0;
          if (bit_cnt_q == '0) begin
            state_d = TRAIL;
          end else begin
            // Shift the register so the next bit is always at the MSB.
            bit_cnt_d = bit_cnt_q - BW'(1);
            tx_sh_d   = tx_next;
            mosi_d    = tx_next[DATA_W-1];
            state_d   = LOW;
          end
        end
      end
      TRAIL: begin
        if (tick) begin
          cs_d      = 1'b0;
          mosi_d    = 1'b0;
          busy_d    = 1'b0;
          rx_data_d = rx_sh_q;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign sclk    = sclk_q;
  assign cs      = cs_q;
  assign mosi    = mosi_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Purpose : directed bench for spi_master with defaults (DATA_W=4, CLK_DIV=2)
//           and a small behavioural slave shifting mosi into a 4-bit leds word.
// Ports   : none (top-level bench).
module tb_spi_master;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] data_in;
  logic       miso;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       busy;
  logic       done;
  logic [3:0] rx_data;

  logic       lb_en;
  logic [3:0] slave_sh;
  logic [3:0] leds;

  int n_checks;
  int n_errors;
  int cyc;
  int cs_cnt;
  int busy_cnt;
  int cs_fall_cyc;
  int cs_rise_cyc;
  logic cs_prev;
  logic mosi_log[$];
  int   done_cyc[$];

  assign miso = lb_en ? mosi : 1'b0;

  spi_master #(
    .DATA_W  (4),
    .CLK_DIV (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .miso    (miso),
    .sclk    (sclk),
    .cs      (cs),
    .mosi    (mosi),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural slave: shift on sclk rise while selected, show word on deselect.
  always @(posedge cs) slave_sh = 4'b0000;
  always @(posedge sclk) begin
    if (cs) slave_sh = {slave_sh[2:0], mosi};
    mosi_log.push_back(mosi);
  end
  always @(negedge cs) leds = slave_sh;

  // Cycle-level monitor, sampled 1 ns after each rising clk edge.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (cs) cs_cnt = cs_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
    if (done) done_cyc.push_back(cyc);
    if (cs_prev && !cs) cs_fall_cyc = cyc;
    if (!cs_prev && cs) cs_rise_cyc = cyc;
    cs_prev = cs;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mosi_seq();
    logic [31:0] v;
    v = 0;
    foreach (mosi_log[i]) v = {v[30:0], mosi_log[i]};
    return v;
  endfunction

  task automatic clear_logs();
    mosi_log.delete();
    done_cyc.delete();
    cs_cnt   = 0;
    busy_cnt = 0;
  endtask

  task automatic send(input logic [3:0] d);
    @(negedge clk);
    start   = 1'b1;
    data_in = d;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Leaves the caller at the falling edge inside the done cycle.
  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    cyc         = 0;
    cs_prev     = 1'b0;
    cs_fall_cyc = 0;
    cs_rise_cyc = 0;
    lb_en       = 1'b0;
    slave_sh    = 4'b0000;
    leds        = 4'b0000;
    rst         = 1'b1;
    start       = 1'b0;
    data_in     = 4'b0000;
    clear_logs();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_cs", 32'(cs), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx", 32'(rx_data), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_no_sclk", 32'(mosi_log.size()), 32'd0);
    chk("idle_no_cs", 32'(cs_cnt), 32'd0);

    // Single transfer 1011
    clear_logs();
    send(4'b1011);
    wait_done("single_done");
    chk("single_rises", 32'(mosi_log.size()), 32'd4);
    chk("single_mosi", mosi_seq(), 32'b1011);
    chk("single_cs_len", 32'(cs_cnt), 32'd18);
    chk("single_busy_len", 32'(busy_cnt), 32'd18);
    chk("single_leds", 32'(leds), 32'b1011);
    chk("single_rx", 32'(rx_data), 32'b0000);
    repeat (5) @(negedge clk);
    chk("single_done_cnt", 32'(done_cyc.size()), 32'd1);

    // Loopback 0110
    clear_logs();
    lb_en = 1'b1;
    send(4'b0110);
    wait_done("loop_done");
    chk("loop_rx", 32'(rx_data), 32'b0110);
    chk("loop_mosi", mosi_seq(), 32'b0110);
    lb_en = 1'b0;
    repeat (3) @(negedge clk);

    // Busy lockout: second start while busy must be ignored
    clear_logs();
    send(4'b1001);
    repeat (3) @(negedge clk);
    start   = 1'b1;
    data_in = 4'b0101;
    @(negedge clk);
    start   = 1'b0;
    wait_done("lock_done");
    repeat (30) @(negedge clk);
    chk("lock_mosi", mosi_seq(), 32'b1001);
    chk("lock_rises", 32'(mosi_log.size()), 32'd4);
    chk("lock_done_cnt", 32'(done_cyc.size()), 32'd1);
    chk("lock_leds", 32'(leds), 32'b1001);

    // Mid-transfer reset after the second sclk rise
    clear_logs();
    send(4'b0100);
    for (int i = 0; i < 40; i++) begin
      if (mosi_log.size() >= 2) break;
      @(negedge clk);
    end
    chk("mid_pre_sclk", 32'(sclk), 32'd1);
    chk("mid_pre_mosi", 32'(mosi), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_async_sclk", 32'(sclk), 32'd0);
    chk("mid_async_cs", 32'(cs), 32'd0);
    chk("mid_async_mosi", 32'(mosi), 32'd0);
    chk("mid_async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("mid_no_done", 32'(done_cyc.size()), 32'd0);
    chk("mid_rx", 32'(rx_data), 32'd0);
    clear_logs();
    send(4'b1111);
    wait_done("mid_after_done");
    chk("mid_after_mosi", mosi_seq(), 32'b1111);
    chk("mid_after_leds", 32'(leds), 32'b1111);
    repeat (3) @(negedge clk);

    // Back-to-back with start held high
    clear_logs();
    @(negedge clk);
    start   = 1'b1;
    data_in = 4'b1100;
    wait_done("b2b_done1");
    chk("b2b_leds1", 32'(leds), 32'b1100);
    chk("b2b_cs_gap", 32'(cs), 32'd0);
    data_in = 4'b0011;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_cs_reassert", 32'(cs), 32'd1);
    chk("b2b_cs_low_len", 32'(cs_rise_cyc - cs_fall_cyc), 32'd1);
    wait_done("b2b_done2");
    chk("b2b_leds2", 32'(leds), 32'b0011);
    chk("b2b_mosi", mosi_seq(), 32'b1100_0011);
    chk("b2b_done_cnt", 32'(done_cyc.size()), 32'd2);
    if (done_cyc.size() == 2)
      chk("b2b_done_gap", 32'(done_cyc[1] - done_cyc[0]), 32'd19);
    else
      chk("b2b_done_gap_count", 32'(done_cyc.size()), 32'd2);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Transmit-side SPI controller that drives the `sclk`/`cs`/`mosi` lines of the board's SPI slave (4-bit LED/seven-segment/PWM path) and captures `miso` in the same transfer. It accepts a parallel word on a start strobe and serialises it MSB first. It generates a divided serial clock and reports completion with a one-cycle `done` pulse. It sits between the control logic and the off-block SPI pins.

## Interface
- `DATA_W`, default 4: bits per transfer; matches the slave's 4-bit shift chain.
- `CLK_DIV`, default 2: `clk` cycles per `sclk` half-period; legal values are 1 or more.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  transfer request; sampled only in IDLE.
- `data_in`  in  DATA_W  word to send; latched when `start` is accepted.
- `miso`  in  1  serial data returned by the slave.
- `sclk`  out  1  serial clock; idles low.
- `cs`  out  1  chip select, active-high, matching the slave's gating; high for the whole transfer.
- `mosi`  out  1  serial data out, MSB first.
- `busy`  out  1  high from acceptance until the transfer ends.
- `done`  out  1  one-cycle completion pulse.
- `rx_data`  out  DATA_W  word captured from `miso`; updated only when `done` pulses.

## Operation
- **Reset values:** `sclk`, `cs`, `mosi`, `busy` and `done` are 0; `rx_data` is 0; the state is IDLE.
- **Mode:** `sclk` idles low. `mosi` changes only while `sclk` is low. The slave samples on the `sclk` rising edge. The master samples `miso` on the `clk` edge that raises `sclk`.
- **States:**
  - IDLE: if `start` is high:
    - latch `data_in` into `tx_sh`;
    - set `bit_cnt` to DATA_W-1;
    - drive `cs` to 1 and `mosi` to `data_in[DATA_W-1]`;
    - go to LEAD.
  - LEAD: hold for CLK_DIV cycles, then raise `sclk`, shift `miso` into `rx_sh` LSB, and go to HIGH.
  - HIGH: hold for CLK_DIV cycles, then drop `sclk`.
    - If `bit_cnt` is 0, go to TRAIL.
    - Otherwise decrement `bit_cnt`, present the next `tx_sh` bit on `mosi`, and go to LOW.
  - LOW: hold for CLK_DIV cycles, then raise `sclk`, sample `miso`, and go to HIGH.
  - TRAIL: hold for CLK_DIV cycles. Then:
    - drive `cs`, `mosi` and `busy` to 0;
    - copy `rx_sh` to `rx_data`;
    - pulse `done`;
    - go to IDLE.
- **Edge count:** exactly DATA_W rising `sclk` edges per transfer. After the transfer, the slave's `leds[DATA_W-1:0]` equals `data_in`.
- **`start` while busy:** ignored, and `data_in` is not re-latched.
- **`start` in the `done` cycle:** accepted, because the FSM is already in IDLE. `cs` is then low for exactly one cycle between transfers.
- **Reset mid-transfer:** all outputs go to reset values immediately (asynchronously). The partial word is discarded and no `done` is issued.
- **Divider:** the half-period counter is `$clog2(CLK_DIV+1)` bits wide. It reloads on every state change and wraps without overflow.

## Timing
- **Latency:** `busy` is high for exactly (2·DATA_W+1)·CLK_DIV cycles, starting the cycle after `start` is accepted. With the defaults this is 18 cycles.
- **`cs` window:** coincident with `busy`.
- **Setup and hold:** the first `sclk` rise comes CLK_DIV cycles after `cs` rises. The last `sclk` fall comes CLK_DIV cycles before `cs` falls.
- **`done`:** asserted in the first cycle after `busy` falls, for exactly 1 cycle. `rx_data` is valid from that cycle on.
- **Registered outputs:** all outputs are registers; there is no combinational path from inputs to outputs.

## Structure
- **Shared package `spi_pkg`:**
  - state enum `spi_state_t` {IDLE, LEAD, HIGH, LOW, TRAIL};
  - constant `SPI_DATA_W = 4`;
  - the package is shared with future slave revisions.
- **Sub-module `spi_tick_gen`:** the half-period counter. It takes `clk`, `rst`, `clear` and parameter `CLK_DIV`, and outputs a one-cycle `tick` every CLK_DIV cycles.
- **Top level:** holds the FSM and the `tx_sh`, `rx_sh` and `bit_cnt` registers.

## Test plan
All scenarios use the defaults (DATA_W=4, CLK_DIV=2).
- **Reset:** hold `rst` high, then release. All outputs are 0 and `rx_data` is 4'b0000. No `sclk` activity with `start`=0.
- **Single transfer:** `start` for 1 cycle with `data_in`=4'b1011, slave instantiated. `mosi` is 1,0,1,1 at the four `sclk` rises, `cs` is high for 18 cycles, `done` pulses once, and the slave's `leds` reads 4'b1011.
- **Loopback:** tie `miso` to `mosi` and send 4'b0110. `rx_data` is 4'b0110 in the `done` cycle.
- **Busy lockout:** send 4'b1001; on cycle 5 pulse `start` with 4'b0101. Only one transfer occurs, `mosi` sequence is 1,0,0,1, and there is one `done`.
- **Mid-transfer reset:** pulse `rst` after the second `sclk` rise. `sclk`, `cs` and `mosi` drop to 0 without waiting for a `clk` edge, and no `done` is issued. A following send of 4'b1111 completes normally.
- **Back-to-back:** hold `start` high with 4'b1100, then 4'b0011. The second `cs` rises exactly 1 cycle after the first falls, and two `done` pulses come 19 cycles apart.
